// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and state type shared by the instruction-fetch aligner.
package fetch_pkg;

  localparam int          FETCH_WORD_W = 64;
  localparam logic [31:0] FETCH_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY,
    HAVE,
    SPLIT
  } fa_state_t;

endpackage

// File: rtl/fetch_hw_sel.sv
// fetch_hw_sel: picks halfword sel and the 32-bit window starting at it from a 64-bit fetch word.
module fetch_hw_sel
  import fetch_pkg::*;
(
  input  logic [FETCH_WORD_W-1:0] word,
  input  logic [1:0]              sel,
  output logic [15:0]             hw,
  output logic [31:0]             win
);

  // The window at halfword 3 runs off the word; only its low half is meaningful.
  always_comb begin
    hw  = word[15:0];
    win = word[31:0];
    case (sel)
      2'd0: begin
        hw  = word[15:0];
        win = word[31:0];
      end
      2'd1: begin
        hw  = word[31:16];
        win = word[47:16];
      end
      2'd2: begin
        hw  = word[47:32];
        win = word[63:32];
      end
      default: begin
        hw  = word[63:48];
        win = {16'h0000, word[63:48]};
      end
    endcase
  end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: extracts the instruction at pc from SRAM read words, zero added latency.
// Define RVC_EN for 16-bit instructions and 32-bit instructions split across two words.
module fetch_align
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    cpurst_n,
  input  logic                    isram_cs_ff,
  input  logic [28:0]             isram_adr_ff,
  input  logic [FETCH_WORD_W-1:0] isram_rdata,
  input  logic [31:0]             pc,
  input  logic                    fet_flush,
  output logic [31:0]             rv32_instr,
  output logic                    isrv16,
  output logic                    instr_valid,
  output logic                    fetch_misalign
);

  fa_state_t               state_q, state_d;
  logic [FETCH_WORD_W-1:0] lw_data_q, lw_data_d;
  logic [28:0]             lw_adr_q, lw_adr_d;
  logic                    lw_vld_q, lw_vld_d;

  logic [28:0]             pc_w;
  logic                    hit_new, hit_lw, hit;
  logic [FETCH_WORD_W-1:0] cur;
  logic [1:0]              sel;
  logic [15:0]             hw0;
  logic [31:0]             win;
  logic                    raw_valid, raw_16;
  logic [31:0]             raw_instr;
  logic                    unused_pc0;

  assign unused_pc0 = pc[0];

  // A word arriving this cycle takes priority over the buffered copy.
  always_comb begin
    pc_w    = pc[31:3];
    hit_new = isram_cs_ff && (isram_adr_ff == pc_w);
    hit_lw  = lw_vld_q && (lw_adr_q == pc_w);
    hit     = hit_new || hit_lw;
    cur     = hit_new ? isram_rdata : lw_data_q;
`ifdef RVC_EN
    sel     = pc[2:1];
`else
    sel     = {pc[2], 1'b0};
`endif
  end

  fetch_hw_sel u_hw_sel (
    .word (cur),
    .sel  (sel),
    .hw   (hw0),
    .win  (win)
  );

`ifdef RVC_EN
  logic [28:0] pc_nx, res_adr_q, res_adr_d;
  logic [15:0] res_hw_q, res_hw_d, lower, up_hw;
  logic        up_new, up_lw, up_ok, res_hit, low_ok, is_split, capture, complete;

  // The upper half of a split instruction lives in halfword 0 of the next word.
  always_comb begin
    pc_nx     = pc_w + 29'd1;
    up_new    = isram_cs_ff && (isram_adr_ff == pc_nx);
    up_lw     = lw_vld_q && (lw_adr_q == pc_nx);
    up_ok     = up_new || up_lw;
    up_hw     = up_new ? isram_rdata[15:0] : lw_data_q[15:0];
    res_hit   = (state_q == SPLIT) && (res_adr_q == pc_w);
    low_ok    = hit || res_hit;
    lower     = hit ? hw0 : res_hw_q;
    raw_16    = (lower[1:0] != 2'b11);
    is_split  = (pc[2:1] == 2'b11) && !raw_16;
    capture   = is_split && hit && !up_ok;
    complete  = is_split && low_ok && up_ok;
    raw_valid = low_ok && (raw_16 || (is_split ? up_ok : hit));
    if (raw_16)
      raw_instr = {16'h0000, lower};
    else if (is_split)
      raw_instr = {up_hw, lower};
    else
      raw_instr = win;
  end
`else
  logic [15:0] unused_hw;

  assign unused_hw = hw0;

  always_comb begin
    raw_16    = 1'b0;
    raw_valid = hit && !pc[1];
    raw_instr = win;
  end
`endif

  // Reset and flush both suppress the output so decode only ever sees a NOP.
  always_comb begin
    instr_valid    = cpurst_n && !fet_flush && raw_valid;
    fetch_misalign = !instr_valid;
    rv32_instr     = instr_valid ? raw_instr : FETCH_NOP;
    isrv16         = instr_valid && raw_16;
  end

  always_comb begin
    state_d   = state_q;
    lw_data_d = lw_data_q;
    lw_adr_d  = lw_adr_q;
    lw_vld_d  = lw_vld_q;
`ifdef RVC_EN
    res_hw_d  = res_hw_q;
    res_adr_d = res_adr_q;
`endif
    if (isram_cs_ff) begin
      lw_data_d = isram_rdata;
      lw_adr_d  = isram_adr_ff;
      lw_vld_d  = 1'b1;
    end
    case (state_q)
      EMPTY: if (isram_cs_ff) state_d = HAVE;
`ifdef RVC_EN
      SPLIT: if (complete) state_d = HAVE;
`endif
      default: ;
    endcase
`ifdef RVC_EN
    if (capture) begin
      state_d   = SPLIT;
      res_hw_d  = hw0;
      res_adr_d = pc_w;
    end
`endif
    // Flush beats a simultaneous SRAM return: that word is dropped.
    if (fet_flush) begin
      state_d   = EMPTY;
      lw_data_d = lw_data_q;
      lw_adr_d  = lw_adr_q;
      lw_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      state_q   <= EMPTY;
      lw_data_q <= '0;
      lw_adr_q  <= '0;
      lw_vld_q  <= 1'b0;
`ifdef RVC_EN
      res_hw_q  <= '0;
      res_adr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lw_data_q <= lw_data_d;
      lw_adr_q  <= lw_adr_d;
      lw_vld_q  <= lw_vld_d;
`ifdef RVC_EN
      res_hw_q  <= res_hw_d;
      res_adr_q <= res_adr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed and random checks of fetch_align against a halfword-availability model.
// Follows RVC_EN the same way the design does.
module tb_fetch_align;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        cpurst_n, isram_cs_ff, fet_flush;
  logic [28:0] isram_adr_ff;
  logic [63:0] isram_rdata;
  logic [31:0] pc;
  logic [31:0] rv32_instr;
  logic        isrv16, instr_valid, fetch_misalign;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the most recent word received, plus a pending lower half of a split instruction.
  logic        m_lw_vld = 1'b0;
  logic [28:0] m_lw_adr = '0;
  logic [63:0] m_lw_data = '0;
  logic        m_res_vld = 1'b0;
  logic [31:0] m_res_pc = '0;
  logic [15:0] m_res_hw = '0;

  logic        exp_valid, exp_16, m_capture, m_complete;
  logic [31:0] exp_instr;
  logic [15:0] m_lower;

  always #5 clk = ~clk;

  fetch_align dut (
    .clk            (clk),
    .cpurst_n       (cpurst_n),
    .isram_cs_ff    (isram_cs_ff),
    .isram_adr_ff   (isram_adr_ff),
    .isram_rdata    (isram_rdata),
    .pc             (pc),
    .fet_flush      (fet_flush),
    .rv32_instr     (rv32_instr),
    .isrv16         (isrv16),
    .instr_valid    (instr_valid),
    .fetch_misalign (fetch_misalign)
  );

  task automatic getHalfword(input logic [31:0] a, output logic found, output logic [15:0] v,
                             output logic from_word);
    logic [63:0] sh;
    found = 1'b0;
    v = 16'h0;
    from_word = 1'b0;
    if (isram_cs_ff && isram_adr_ff == a[31:3]) begin
      sh = isram_rdata >> (32'(a[2:1]) * 16);
      found = 1'b1; v = sh[15:0]; from_word = 1'b1;
    end else if (m_lw_vld && m_lw_adr == a[31:3]) begin
      sh = m_lw_data >> (32'(a[2:1]) * 16);
      found = 1'b1; v = sh[15:0]; from_word = 1'b1;
    end else if (m_res_vld && m_res_pc == a) begin
      found = 1'b1; v = m_res_hw;
    end
  endtask

  task automatic modelEval();
    logic lf, l_word, uf, u_word;
    logic [15:0] lv, uv;
    exp_valid = 1'b0; exp_16 = 1'b0; exp_instr = FETCH_NOP;
    m_capture = 1'b0; m_complete = 1'b0;
    getHalfword(pc, lf, lv, l_word);
    getHalfword(pc + 32'd2, uf, uv, u_word);
    m_lower = lv;
    if (cpurst_n && !fet_flush && lf) begin
`ifdef RVC_EN
      if (lv[1:0] != 2'b11) begin
        exp_valid = 1'b1; exp_16 = 1'b1; exp_instr = {16'h0, lv};
      end else if (uf) begin
        exp_valid = 1'b1; exp_instr = {uv, lv};
        m_complete = (pc[2:1] == 2'b11) && (u_word || !u_word);
      end else begin
        m_capture = (pc[2:1] == 2'b11) && l_word;
      end
`else
      if (!pc[1] && uf && l_word && u_word) begin
        exp_valid = 1'b1; exp_instr = {uv, lv};
      end
`endif
    end
  endtask

  task automatic modelUpdate();
    if (!cpurst_n) begin
      m_lw_vld = 1'b0; m_lw_data = '0; m_res_vld = 1'b0;
    end else if (fet_flush) begin
      m_lw_vld = 1'b0; m_res_vld = 1'b0;
    end else begin
      if (m_capture) begin
        m_res_vld = 1'b1; m_res_pc = pc; m_res_hw = m_lower;
      end else if (m_complete) begin
        m_res_vld = 1'b0;
      end
      if (isram_cs_ff) begin
        m_lw_vld = 1'b1; m_lw_adr = isram_adr_ff; m_lw_data = isram_rdata;
      end
    end
  endtask

  task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h (pc=%h)", tag, obs, exp, pc);
    end
  endtask

  task automatic applyStimulus(input logic rst_n_i, input logic cs_i, input logic [28:0] adr_i,
                               input logic [63:0] data_i, input logic [31:0] pc_i,
                               input logic flush_i);
    cpurst_n = rst_n_i;
    isram_cs_ff = cs_i;
    isram_adr_ff = adr_i;
    isram_rdata = data_i;
    pc = pc_i;
    fet_flush = flush_i;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    modelEval();
    cmp32({tag, ".instr"}, rv32_instr, exp_instr);
    cmp32({tag, ".rv16"}, {31'b0, isrv16}, {31'b0, exp_16});
    cmp32({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, exp_valid});
    cmp32({tag, ".misalign"}, {31'b0, fetch_misalign}, {31'b0, !exp_valid});
  endtask

  task automatic advance();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic rst_n_i, input logic cs_i,
                      input logic [28:0] adr_i, input logic [63:0] data_i,
                      input logic [31:0] pc_i, input logic flush_i);
    applyStimulus(rst_n_i, cs_i, adr_i, data_i, pc_i, flush_i);
    checkOutput(tag);
    advance();
  endtask

  // Leaves the lower half of a split instruction at 0x10E pending with no word buffering it.
  task automatic buildResidue();
    step("res_a", 1, 1, 29'h21, 64'h0077_0000_0000_0000, 32'h10E, 0);
    step("res_b", 1, 1, 29'h30, 64'h5555_6666_7777_8888, 32'h10E, 0);
    step("res_c", 1, 0, 29'h0, 64'h0, 32'h10E, 0);
  endtask

  initial begin
    logic [63:0] d;
    logic [31:0] p;
    applyStimulus(0, 0, 29'h0, 64'h0, 32'h0, 0);
    advance();

    step("rst1", 0, 1, 29'h20, 64'h00000013_00A00093, 32'h100, 0);
    applyStimulus(0, 1, 29'h20, 64'h00000013_00A00093, 32'h100, 0);
    checkOutput("rst2");
    cmp32("rst_nop", rv32_instr, 32'h0000_0013);
    cmp32("rst_misalign", {31'b0, fetch_misalign}, 32'd1);
    advance();

    applyStimulus(1, 1, 29'h20, 64'h00000013_00A00093, 32'h100, 0);
    checkOutput("hit32");
    cmp32("hit32_const", rv32_instr, 32'h00A00093);
    advance();

    step("buf_load", 1, 1, 29'h20, 64'h1234_4501_00A0_0093, 32'h100, 0);
    applyStimulus(1, 0, 29'h0, 64'h0, 32'h104, 0);
    checkOutput("buf16");
`ifdef RVC_EN
    cmp32("buf16_const", rv32_instr, 32'h0000_4501);
`else
    cmp32("buf32_const", rv32_instr, 32'h1234_4501);
`endif
    advance();

    step("flush0", 1, 0, 29'h0, 64'h0, 32'h0, 1);
    step("split1", 1, 1, 29'h20, 64'h0093_0000_0000_0000, 32'h106, 0);
    applyStimulus(1, 1, 29'h21, 64'h0000_0000_0000_00A0, 32'h106, 0);
    checkOutput("split2");
`ifdef RVC_EN
    cmp32("split2_const", rv32_instr, 32'h00A0_0093);
`else
    cmp32("split2_const", rv32_instr, FETCH_NOP);
`endif
    advance();

    step("flush1", 1, 0, 29'h0, 64'h0, 32'h0, 1);
    buildResidue();
    step("res_done", 1, 1, 29'h22, 64'h0000_0000_0000_00A0, 32'h10E, 0);

    buildResidue();
    applyStimulus(1, 1, 29'h22, 64'h0000_0000_0000_1111, 32'h10E, 1);
    checkOutput("flush_cs");
    cmp32("flush_cs_valid", {31'b0, instr_valid}, 32'd0);
    advance();
    applyStimulus(1, 0, 29'h0, 64'h0, 32'h110, 0);
    checkOutput("after_flush");
    cmp32("after_flush_valid", {31'b0, instr_valid}, 32'd0);
    advance();
    step("after_flush_res", 1, 0, 29'h0, 64'h0, 32'h10E, 0);

    buildResidue();
    step("rst_split", 0, 0, 29'h0, 64'h0, 32'h10E, 0);
    applyStimulus(1, 1, 29'h22, 64'h0000_0000_0000_00A0, 32'h10E, 0);
    checkOutput("post_rst");
    cmp32("post_rst_valid", {31'b0, instr_valid}, 32'd0);
    advance();

    step("flush2", 1, 0, 29'h0, 64'h0, 32'h0, 1);
    step("top_word", 1, 1, 29'h1FFF_FFFF, 64'h0033_2222_ABCD_1233, 32'hFFFF_FFFC, 0);
    step("wrap1", 1, 1, 29'h1FFF_FFFF, 64'h0033_2222_ABCD_1233, 32'hFFFF_FFFE, 0);
    applyStimulus(1, 1, 29'h0, 64'h0000_0000_0000_ABCD, 32'hFFFF_FFFE, 0);
    checkOutput("wrap2");
`ifdef RVC_EN
    cmp32("wrap2_const", rv32_instr, 32'hABCD_0033);
`else
    cmp32("wrap2_const", rv32_instr, FETCH_NOP);
`endif
    advance();

    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 9) < 6) d[16*k +: 2] = 2'b11;
      p = 32'h100 + 32'($urandom_range(0, 15)) * 2;
      step("rand", ($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
           29'h20 + 29'($urandom_range(0, 2)), d, p, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction-fetch response aligner: consumes the 64-bit words returned by the instruction SRAM one cycle after each `isram_cs`, and extracts the 16- or 32-bit instruction at the current `pc`. It buffers the last returned word and a 16-bit residue, so that a 32-bit instruction straddling an 8-byte boundary is assembled from two fetches. It drives `rv32_instr`, `isrv16` and `fetch_misalign` back to the PC generator and decode stage.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `cpurst_n` in 1: synchronous, active-low reset.
- `isram_cs_ff` in 1: `isram_rdata` is valid this cycle (SRAM read latency 1).
- `isram_adr_ff` in 29: `[31:3]` address of the word on `isram_rdata`.
- `isram_rdata` in 64: SRAM read word; halfword k occupies bits `[16k+15:16k]`.
- `pc` in 32: address of the instruction being fetched this cycle.
- `fet_flush` in 1: discard all buffered state; a redirect or branch mispredict has occurred.
- `rv32_instr` out 32: aligned instruction; 16-bit instructions are zero-extended.
- `isrv16` out 1: the output instruction is compressed (`bits[1:0]!=2'b11`).
- `instr_valid` out 1: `rv32_instr` is complete and usable this cycle.
- `fetch_misalign` out 1: the instruction at `pc` is not yet available; equals `!instr_valid`.

## Operation
- **Registers**
  - `lw_data[63:0]`, `lw_adr[31:3]`, `lw_vld`: last word. Loaded whenever `isram_cs_ff` is high.
  - `res_hw[15:0]`, `res_adr[31:3]`: split residue.
  - `state`: one of EMPTY, HAVE, SPLIT.
- **Word source**
  - `cur` = `isram_rdata` if `isram_cs_ff && isram_adr_ff==pc[31:3]`.
  - Otherwise `cur` = `lw_data` if `lw_vld && lw_adr==pc[31:3]`.
  - Otherwise there is no word (miss).
- **Halfword select:** `hw0 = cur[pc[2:1]]`. The instruction is 16-bit if `hw0[1:0]!=2'b11`.
- **Non-split case** (`pc[2:1]!=3`, or a 16-bit instruction):
  - On a hit: `rv32_instr = isrv16 ? {16'h0,hw0} : cur[pc[2:1]*16 +: 32]`, `instr_valid=1`.
  - On a miss: `instr_valid=0`.
- **Split case** (`pc[2:1]==3` and a 32-bit instruction):
  - Upper half = `isram_rdata[15:0]` when `isram_cs_ff` and `isram_adr_ff==pc[31:3]+1`.
  - Otherwise upper half = `lw_data[15:0]` when `lw_adr==pc[31:3]+1`.
  - Lower half = `hw0` if the pc word is present. Otherwise lower half = `res_hw` when state is SPLIT and `res_adr==pc[31:3]`.
  - Valid only when both halves are found.
- **State transitions**
  - EMPTY→HAVE on `isram_cs_ff`.
  - HAVE→SPLIT when a split-case lower half is captured but the upper half is missing. `res_hw<=hw0`, `res_adr<=pc[31:3]`.
  - SPLIT→HAVE when the upper half arrives.
  - any→EMPTY on `fet_flush`.
- **Invalid cycles:** when `instr_valid=0`, `rv32_instr` = NOP `32'h0000_0013` and `isrv16=0`. This keeps downstream mini-decode from seeing spurious jumps.
- **Address arithmetic:** `pc[31:3]+1` is 29-bit modulo; `29'h1FFF_FFFF+1` wraps to 0.

## Timing
- Outputs are combinational from `isram_rdata` and the registers. The block adds zero latency beyond the SRAM.
- State and buffers update on the rising edge of `clk`.
- **Reset** (`cpurst_n=0` at the edge):
  - state EMPTY, `lw_vld=0`, `lw_data=0`, `res_hw=0`.
  - While held in reset: `rv32_instr=32'h13`, `isrv16=0`, `instr_valid=0`, `fetch_misalign=1`.
- **Reset mid-SPLIT:** the residue is discarded and there is no output on the following cycle.
- **`fet_flush` together with `isram_cs_ff`:** flush wins. The returned word is not loaded, `lw_vld<=0`, and outputs for that cycle are forced invalid.
- **`fet_flush` in SPLIT:** go to EMPTY; `res_hw` is not used again.
- **`isram_cs_ff` with a non-matching address:** the word is still loaded into `lw_*`, and the output reflects the miss.

## Configuration
- **`RVC_EN` defined:** full behaviour as above.
- **`RVC_EN` undefined:**
  - `isrv16=0` always.
  - The SPLIT state and residue registers are removed.
  - `pc[1]` is ignored; the instruction is `cur[pc[2]*32 +: 32]`.
  - Any `pc[1]=1` forces `instr_valid=0`.

## Structure
- Shared package `fetch_pkg`:
  - `FETCH_NOP = 32'h0000_0013`.
  - `fa_state_t` enum (EMPTY, HAVE, SPLIT).
  - `FETCH_WORD_W = 64`.
- One sub-module `fetch_hw_sel`: combinational 4:1 halfword and 32-bit window mux from a 64-bit word and `pc[2:1]`. Instantiated for `cur`.

## Test plan
- **Reset:** `cpurst_n=0` for 2 cycles → `rv32_instr=32'h13`, `instr_valid=0`, `fetch_misalign=1`.
- **32-bit hit:** `pc=32'h100`, `isram_cs_ff=1`, `isram_adr_ff=29'h20`, `isram_rdata=64'h00000013_00A00093` → `rv32_instr=32'h00A00093`, `isrv16=0`, `instr_valid=1`.
- **16-bit from buffer:** buffered word at `pc=32'h104` with `rdata[47:32]=16'h4501` → `rv32_instr=32'h00004501`, `isrv16=1` on the following cycle, with no new fetch.
- **Split instruction:**
  - Stimulus: `pc=32'h106`, word `0x100` with `[63:48]=16'h0093`, then word `0x108` one cycle later with `[15:0]=16'h00A0`.
  - Response: cycle 1 `fetch_misalign=1`; cycle 2 `rv32_instr=32'h00A00093`, `instr_valid=1`.
- **Flush collision:** `fet_flush=1` with `isram_cs_ff=1` during SPLIT → next cycle state is EMPTY and `instr_valid=0` even though `pc` matches the discarded word.
- **Wrap:** `pc=32'hFFFF_FFFE`, 32-bit split → the upper half is taken from the word at `isram_adr_ff=29'h0`.
